mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store front end placed directly upstream of the core's single-port word-wide block RAM.
- Accepts one CPU memory request at a time and checks alignment and range.
- Issues the RAM accesses. Byte and halfword stores use read-modify-write because the RAM has one word-wide write enable.
- Returns aligned, sign- or zero-extended load data.

Parameters:
- MEM_BYTES, 1048576: byte size of the attached RAM (262144 words). Addresses at or above this are errors.
- RESP_ON_STORE, 1: when 1, stores also produce a resp_valid pulse.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend loads when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, in the low bits for byte/half.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned, out-of-range or illegal-size request; qualified by resp_valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  byte address to RAM; RAM uses addr[31:2].
- ram_di  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid the cycle after a read with ram_en=1.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; resp_valid=0; resp_err=0; resp_rdata=0.
  - Captured request registers cleared.
  - req_ready=0 and ram_en=0 while rst is low.
  - A sub-word store interrupted by reset leaves RAM unchanged.
- States: IDLE, LOAD_WAIT, RMW_WRITE.
- req_ready=1 only in IDLE with rst high.
- Accept cycle T (IDLE):
  - Capture addr, size, unsigned and wdata.
  - RAM drive in cycle T is combinational from the req_* inputs.
- Error check at T: any of the following gives no RAM access, stay in IDLE, and at T+1 resp_valid=1, resp_err=1, rdata=0.
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr >= MEM_BYTES.
- Load:
  - At T: ram_en=1, ram_we=0, ram_addr=req_addr.
  - At T+1 (LOAD_WAIT): extract from ram_dout and register into resp_rdata.
  - At T+2: resp_valid=1, state=IDLE, req_ready=1. A new request may be accepted at T+2.
- Word store:
  - At T: ram_en=1, ram_we=1, ram_di=req_wdata.
  - At T+1: resp_valid=1 (if RESP_ON_STORE), resp_err=0.
  - Stays in IDLE, so back-to-back word stores are allowed every cycle.
- Byte/half store:
  - At T: read word (ram_we=0).
  - At T+1 (RMW_WRITE): ram_en=1, ram_we=1, ram_di = ram_dout with the selected lane replaced by the captured wdata low bits.
  - At T+2: resp_valid=1, state=IDLE.
- Lane mapping is little-endian:
  - Byte k = addr[1:0] maps to bits [8k+7:8k].
  - Half h = addr[1] maps to bits [16h+15:16h].
- Extension: sign-extend from bit 7 or bit 15 unless req_unsigned. Word loads are passed through.
- resp_valid is a single-cycle registered pulse. The CPU always accepts responses; there is no response backpressure.
- RAM is read-first. A load accepted at the cycle after a store to the same word sees the new data, because the write completed at the prior edge.
- ram_* outputs are 0 in any cycle with no access.

Decomposition:
- Package cpu_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum.
  - MEM_BYTES default.
- Sub-module mem_lane_align (combinational):
  - load_extract(word, addr[1:0], size, unsigned).
  - store_merge(old, wdata, addr[1:0], size).
  - Instantiated once for each function.

Test Plan:
- Word store 0xDEADBEEF at 0x100, then load word at 0x100 accepted the next cycle -> store resp at T+1; load resp_rdata=0xDEADBEEF exactly 2 cycles after accept; resp_err=0.
- RAM word 0x80F0_7F01 at 0x200; signed byte loads at 0x200/0x201/0x203 -> 0x00000001, 0x0000007F, 0xFFFFFF80. Unsigned byte load at 0x203 -> 0x00000080. Signed half load at 0x202 -> 0xFFFF80F0.
- RAM word 0x11223344 at 0x300; byte store 0xAB at 0x302 -> write issued at T+1 with ram_di=0x11AB3344, resp at T+2. Then half store 0xCAFE at 0x300 -> word 0x11ABCAFE.
- Errors:
  - half at 0x101, word at 0x102, size=11, word at MEM_BYTES -> each gives resp_valid and resp_err at T+1, resp_rdata=0, ram_en never asserted.
- Reset during RMW_WRITE cycle (rst low asynchronously) -> immediate IDLE, resp_valid=0, ram_we=0, RAM word unchanged. After rst high, req_ready=1 next cycle.
- Eight back-to-back word stores with req_valid held high -> one accepted per cycle, eight resp pulses on consecutive cycles. Subsequent loads read all eight values correctly.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states, RAM size.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_WRITE = 2'b10
    } state_e;

    localparam int unsigned DEF_MEM_BYTES = 1048576;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response handshake plus the word-wide RAM port of the load/store unit.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    // CPU side
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // The load/store unit itself
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_dout
    );

    // Attached block RAM
    modport ram (
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_dout
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: MERGE=0 extracts/extends load data, MERGE=1 merges
// sub-word store data into the old RAM word.
module mem_lane_align
    import cpu_mem_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] dout
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext;
    logic [31:0] mrg;

    // Select the addressed lane, then either extend it or overwrite it
    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        ext    = word;
        mrg    = word;
        case (size)
            SZ_BYTE: begin
                ext = {{24{~uns & byte_v[7]}}, byte_v};
                mrg[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ext = {{16{~uns & half_v[15]}}, half_v};
                mrg[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ext = word;
                mrg = wdata;
            end
        endcase
        dout = MERGE ? mrg : ext;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a single-port word RAM: checks requests, runs
// read-modify-write for sub-word stores, returns extended load data.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES     = DEF_MEM_BYTES,
    parameter bit          RESP_ON_STORE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        rv_q, rv_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        bad_req;
    logic [31:0] ld_word;
    logic [31:0] st_word;

    mem_lane_align #(.MERGE(1'b0)) u_load_extract (
        .word  (bus.ram_dout),
        .wdata (32'h0),
        .off   (addr_q[1:0]),
        .size  (size_q),
        .uns   (uns_q),
        .dout  (ld_word)
    );

    mem_lane_align #(.MERGE(1'b1)) u_store_merge (
        .word  (bus.ram_dout),
        .wdata (wdata_q),
        .off   (addr_q[1:0]),
        .size  (size_q),
        .uns   (1'b0),
        .dout  (st_word)
    );

    // Request legality: size encoding, natural alignment, RAM range
    always_comb begin
        bad_req = 1'b0;
        case (bus.req_size)
            SZ_BYTE: bad_req = 1'b0;
            SZ_HALF: bad_req = bus.req_addr[0];
            SZ_WORD: bad_req = |bus.req_addr[1:0];
            default: bad_req = 1'b1;
        endcase
        if (bus.req_addr >= MEM_LIMIT) bad_req = 1'b1;
    end

    // Next state, capture, and RAM drive; RAM port idles at zero when unused
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        uns_d         = uns_q;
        rv_d          = 1'b0;
        err_d         = 1'b0;
        rdata_d       = 32'h0;
        bus.req_ready = (state_q == IDLE) && rst;
        accept        = bus.req_valid && bus.req_ready;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = 32'h0;
        bus.ram_di    = 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    if (bad_req) begin
                        rv_d  = 1'b1;
                        err_d = 1'b1;
                    end else if (!bus.req_we) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.req_addr;
                        state_d      = LOAD_WAIT;
                    end else if (bus.req_size == SZ_WORD) begin
                        // Full-word store needs no read; stay in IDLE for back-to-back
                        bus.ram_en   = 1'b1;
                        bus.ram_we   = 1'b1;
                        bus.ram_addr = bus.req_addr;
                        bus.ram_di   = bus.req_wdata;
                        rv_d         = RESP_ON_STORE;
                    end else begin
                        // Sub-word store: fetch the old word first
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.req_addr;
                        state_d      = RMW_WRITE;
                    end
                end
            end
            LOAD_WAIT: begin
                rdata_d = ld_word;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            RMW_WRITE: begin
                bus.ram_en   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = addr_q;
                bus.ram_di   = st_word;
                rv_d         = RESP_ON_STORE;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;

endmodule
